// File: rtl/multichannel_sigdel_modulator.sv
// Time-multiplexed sigma-delta modulator bank.
// One shared first/second-order datapath walks the channels on cnt = 0..CHANNELS-1
// of every DIV-cycle period. Per-channel integrator state lives in small register
// banks. All output bits are published together once the last channel is done.
//
// state (cnt)          | meaning
// 0 .. CHANNELS-1      | update channel cnt; cnt = CHANNELS-1 also loads outputs
// CHANNELS .. DIV-1    | idle slots, integrators held
module multichannel_sigdel_modulator #(
   parameter int CHANNELS    = 4,
   parameter int INPUT_WIDTH = 24,
   parameter int ACC_GUARD   = 4,
   parameter int DIV         = 10
) (
   input  logic                            clock,
   input  logic                            reset_n,
   input  logic                            enable,
   input  logic                            clear,
   input  logic [CHANNELS-1:0]             order_2nd,
   input  logic [CHANNELS*INPUT_WIDTH-1:0] input_data,
   output logic [CHANNELS-1:0]             output_bitstreams,
   output logic                            bit_valid,
   output logic [CHANNELS-1:0]             overflow,
   input  logic                            overflow_clear
);

   localparam int ACC = INPUT_WIDTH + ACC_GUARD;
   localparam int SW  = ACC + 2;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_LOAD  = CW'(CHANNELS - 1);
   localparam logic [CW-1:0] CNT_CHANS = CW'(CHANNELS);

   // Clamp limits of the integrators, expressed at sum width.
   localparam logic signed [SW-1:0]  SUM_MAX = {3'b000, {(ACC-1){1'b1}}};
   localparam logic signed [SW-1:0]  SUM_MIN = {3'b111, {(ACC-1){1'b0}}};
   localparam logic signed [ACC-1:0] ACC_MAX = {1'b0, {(ACC-1){1'b1}}};
   localparam logic signed [ACC-1:0] ACC_MIN = {1'b1, {(ACC-1){1'b0}}};

   // Full-scale feedback levels, already sign-extended to sum width.
   localparam logic signed [SW-1:0] FB_POS = {{(SW-INPUT_WIDTH+1){1'b0}}, {(INPUT_WIDTH-1){1'b1}}};
   localparam logic signed [SW-1:0] FB_NEG = {{(SW-INPUT_WIDTH+1){1'b1}}, {(INPUT_WIDTH-1){1'b0}}};

   logic [CW-1:0]              cnt_q;
   logic signed [ACC-1:0]      i1_q [CHANNELS];
   logic signed [ACC-1:0]      i2_q [CHANNELS];
   logic [CHANNELS-1:0]        shadow_q;

   logic signed [INPUT_WIDTH-1:0] x_arr [CHANNELS];
   logic [CHW-1:0]             ch;
   logic                       upd;
   logic signed [SW-1:0]       x_ext, i1_ext, i2_ext, i1n_ext, fb;
   logic signed [SW-1:0]       sum1, sum2;
   logic signed [ACC-1:0]      i1_n, i2_n;
   logic                       clip;
   logic                       bit_n;
   logic [CHANNELS-1:0]        shadow_n;
   logic [CHANNELS-1:0]        overflow_n;

   function automatic logic signed [ACC-1:0] sat_acc(input logic signed [SW-1:0] s);
      if (s > SUM_MAX)
         sat_acc = ACC_MAX;
      else if (s < SUM_MIN)
         sat_acc = ACC_MIN;
      else
         sat_acc = s[ACC-1:0];
   endfunction

   function automatic logic is_clip(input logic signed [SW-1:0] s);
      is_clip = (s > SUM_MAX) || (s < SUM_MIN);
   endfunction

   for (genvar c = 0; c < CHANNELS; c++) begin : g_unpack
      assign x_arr[c] = input_data[c*INPUT_WIDTH +: INPUT_WIDTH];
   end

   // Idle slots point at channel 0 so the array select never leaves its range.
   assign ch  = (cnt_q < CNT_CHANS) ? cnt_q[CHW-1:0] : '0;
   assign upd = enable && !clear && (cnt_q < CNT_CHANS);

   // Shared datapath: one integrator step for the channel selected by cnt.
   always_comb begin
      x_ext   = {{(SW-INPUT_WIDTH){x_arr[ch][INPUT_WIDTH-1]}}, x_arr[ch]};
      i1_ext  = {{2{i1_q[ch][ACC-1]}}, i1_q[ch]};
      i2_ext  = {{2{i2_q[ch][ACC-1]}}, i2_q[ch]};
      fb      = shadow_q[ch] ? FB_POS : FB_NEG;
      sum1    = i1_ext + x_ext - fb;
      i1_n    = sat_acc(sum1);
      i1n_ext = {{2{i1_n[ACC-1]}}, i1_n};
      sum2    = i2_ext + i1n_ext - fb;
      i2_n    = '0;
      clip    = is_clip(sum1);
      bit_n   = ~i1_n[ACC-1];
      if (order_2nd[ch]) begin
         i2_n  = sat_acc(sum2);
         clip  = is_clip(sum1) || is_clip(sum2);
         bit_n = ~i2_n[ACC-1];
      end
      shadow_n = shadow_q;
      if (upd)
         shadow_n[ch] = bit_n;
   end

   // Sticky flags: a clamp on this edge beats a simultaneous clear request.
   always_comb begin
      overflow_n = overflow_clear ? '0 : overflow;
      if (upd && clip)
         overflow_n[ch] = 1'b1;
   end

   // Period counter, integrator banks, shadow bits and published outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q             <= '0;
         shadow_q          <= '0;
         output_bitstreams <= '0;
         bit_valid         <= 1'b0;
         for (int c = 0; c < CHANNELS; c++) begin
            i1_q[c] <= '0;
            i2_q[c] <= '0;
         end
      end else if (clear) begin
         cnt_q             <= '0;
         shadow_q          <= '0;
         output_bitstreams <= '0;
         bit_valid         <= 1'b0;
         for (int c = 0; c < CHANNELS; c++) begin
            i1_q[c] <= '0;
            i2_q[c] <= '0;
         end
      end else begin
         bit_valid <= 1'b0;
         if (enable) begin
            cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
            if (upd) begin
               i1_q[ch] <= i1_n;
               i2_q[ch] <= i2_n;
               shadow_q <= shadow_n;
            end
            if (cnt_q == CNT_LOAD) begin
               output_bitstreams <= shadow_n;
               bit_valid         <= 1'b1;
            end
         end
      end
   end

   // Overflow flags survive the synchronous clear; only reset or overflow_clear drop them.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         overflow <= '0;
      else
         overflow <= overflow_n;
   end

endmodule

// File: tb/tb_multichannel_sigdel_modulator.sv
// Bench for multichannel_sigdel_modulator: two instances share all stimulus,
// one with ACC_GUARD=4 (dut) and one with ACC_GUARD=0 (dut_g0) for clamp tests.
module tb_multichannel_sigdel_modulator;

   localparam int CH  = 4;
   localparam int IW  = 24;
   localparam int DIV = 10;
   localparam longint FULL_POS = 64'sd8388607;
   localparam longint FULL_NEG = -64'sd8388608;

   logic          clock = 1'b0;
   logic          reset_n, enable, clear, overflow_clear;
   logic [CH-1:0] order_2nd;
   logic [CH*IW-1:0] input_data;
   logic [CH-1:0] out_a, out_b, ovf_a, ovf_b;
   logic          bv_a, bv_b;

   always #5 clock = ~clock;

   multichannel_sigdel_modulator #(.CHANNELS(CH), .INPUT_WIDTH(IW), .ACC_GUARD(4), .DIV(DIV)) dut (
      .clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear),
      .order_2nd(order_2nd), .input_data(input_data),
      .output_bitstreams(out_a), .bit_valid(bv_a), .overflow(ovf_a),
      .overflow_clear(overflow_clear));

   multichannel_sigdel_modulator #(.CHANNELS(CH), .INPUT_WIDTH(IW), .ACC_GUARD(0), .DIV(DIV)) dut_g0 (
      .clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear),
      .order_2nd(order_2nd), .input_data(input_data),
      .output_bitstreams(out_b), .bit_valid(bv_b), .overflow(ovf_b),
      .overflow_clear(overflow_clear));

   typedef struct packed {
      logic [CH-1:0] a;
      logic [CH-1:0] b;
   } exp_t;

   typedef struct {
      logic [CH-1:0]         ord;
      logic [CH-1:0][31:0]   x;
      int                    periods;
      logic [CH-1:0][15:0]   lo;
      logic [CH-1:0][15:0]   hi;
   } row_t;

   exp_t   sbq[$];
   row_t   rows[3];
   int     cur_x[CH];
   longint mi1[2][CH];
   longint mi2[2][CH];
   bit     msh[2][CH];
   int     ones[CH];
   int     n_chk  = 0;
   int     n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_chk++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
      end
   endtask

   task automatic chk_rng(input string name, input int v, input int lo, input int hi);
      n_chk++;
      if (v < lo || v > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, v, lo, hi);
      end
   endtask

   function automatic longint sat_m(input longint s, input int acc);
      longint hi, lo;
      hi = (64'sd1 <<< (acc - 1)) - 1;
      lo = -(64'sd1 <<< (acc - 1));
      if (s > hi) return hi;
      if (s < lo) return lo;
      return s;
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < 2; i++)
         for (int c = 0; c < CH; c++) begin
            mi1[i][c] = 0;
            mi2[i][c] = 0;
            msh[i][c] = 1'b0;
         end
   endfunction

   // One full period of both instances, using the inputs currently driven.
   function automatic void model_step();
      longint fb, n1, n2;
      int acc;
      for (int i = 0; i < 2; i++) begin
         acc = (i == 0) ? IW + 4 : IW;
         for (int c = 0; c < CH; c++) begin
            fb = msh[i][c] ? FULL_POS : FULL_NEG;
            n1 = sat_m(mi1[i][c] + longint'(cur_x[c]) - fb, acc);
            if (order_2nd[c]) begin
               n2 = sat_m(mi2[i][c] + n1 - fb, acc);
               msh[i][c] = (n2 >= 0);
            end else begin
               n2 = 0;
               msh[i][c] = (n1 >= 0);
            end
            mi1[i][c] = n1;
            mi2[i][c] = n2;
         end
      end
   endfunction

   task automatic drive();
      for (int c = 0; c < CH; c++)
         input_data[c*IW +: IW] = cur_x[c][IW-1:0];
   endtask

   task automatic push_expect();
      exp_t e;
      model_step();
      for (int c = 0; c < CH; c++) begin
         e.a[c] = msh[0][c];
         e.b[c] = msh[1][c];
      end
      sbq.push_back(e);
   endtask

   task automatic wait_pop(input int exp_lat, input string tag);
      int   n;
      bit   got;
      exp_t e;
      n   = 0;
      got = 1'b0;
      while (!got && n < 3 * DIV) begin
         @(negedge clock);
         n++;
         got = bv_a;
      end
      chk({tag, "_valid_seen"}, {31'd0, got}, 32'd1);
      chk({tag, "_latency"}, n, exp_lat);
      chk({tag, "_valid_g0"}, {31'd0, bv_b}, 32'd1);
      if (sbq.size() == 0) begin
         chk({tag, "_scoreboard_nonempty"}, 32'd0, 32'd1);
      end else begin
         e = sbq.pop_front();
         chk({tag, "_bits"}, {28'd0, out_a}, {28'd0, e.a});
         chk({tag, "_bits_g0"}, {28'd0, out_b}, {28'd0, e.b});
         for (int c = 0; c < CH; c++)
            ones[c] += int'(out_a[c]);
      end
   endtask

   task automatic do_period(input int exp_lat, input string tag);
      drive();
      push_expect();
      wait_pop(exp_lat, tag);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(negedge clock);
      clear = 1'b0;
      model_clear();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [CH-1:0] prev;
      bit changed;

      // ch3..ch0
      rows[0].ord = 4'b1011;
      rows[0].x   = {32'sd2097152, 32'sd2097152, 32'sd8000000, 32'sd0};
      rows[0].periods = 2000;
      rows[0].lo  = {16'd1244, 16'd1244, 16'd1948, 16'd998};
      rows[0].hi  = {16'd1256, 16'd1256, 16'd1960, 16'd1002};
      rows[1].ord = 4'b0000;
      rows[1].x   = {-32'sd8000000, 32'sd4194304, 32'sd0, -32'sd2097152};
      rows[1].periods = 400;
      rows[1].lo  = {16'd6, 16'd297, 16'd197, 16'd147};
      rows[1].hi  = {16'd12, 16'd303, 16'd203, 16'd153};
      rows[2].ord = 4'b1111;
      rows[2].x   = {32'sd6000000, -32'sd1000000, 32'sd1000000, -32'sd4194304};
      rows[2].periods = 400;
      rows[2].lo  = {16'd337, 16'd170, 16'd218, 16'd94};
      rows[2].hi  = {16'd349, 16'd182, 16'd230, 16'd106};

      reset_n = 1'b0;
      enable = 1'b0;
      clear = 1'b0;
      overflow_clear = 1'b0;
      order_2nd = 4'b1111;
      for (int c = 0; c < CH; c++) cur_x[c] = 0;
      drive();
      model_clear();

      // Reset state
      repeat (2) @(negedge clock);
      chk("reset_bits", {28'd0, out_a}, 32'd0);
      chk("reset_valid", {31'd0, bv_a}, 32'd0);
      chk("reset_ovf", {28'd0, ovf_a}, 32'd0);
      chk("reset_ovf_g0", {28'd0, ovf_b}, 32'd0);
      reset_n = 1'b1;
      @(negedge clock);

      // Period timing: zero input, all second order -> 1111, 1111, 0000
      enable = 1'b1;
      prev = out_a;
      for (int k = 0; k < 25; k++) begin
         @(posedge clock);
         #1;
         chk($sformatf("timing_valid_E%0d", k), {31'd0, bv_a},
             {31'd0, (k == 3 || k == 13 || k == 23)});
         changed = (out_a !== prev);
         chk($sformatf("timing_change_E%0d", k), {31'd0, changed},
             {31'd0, (k == 3 || k == 23)});
         if (k == 3)  chk("timing_bits_E3", {28'd0, out_a}, 32'hF);
         if (k == 23) chk("timing_bits_E23", {28'd0, out_a}, 32'h0);
         prev = out_a;
      end
      @(negedge clock);

      // Table rows: exact bits via scoreboard, densities against DC level
      for (int r = 0; r < 3; r++) begin
         order_2nd = rows[r].ord;
         for (int c = 0; c < CH; c++) cur_x[c] = $signed(rows[r].x[c]);
         do_clear();
         for (int c = 0; c < CH; c++) ones[c] = 0;
         for (int p = 0; p < rows[r].periods; p++)
            do_period((p == 0) ? 4 : DIV, $sformatf("row%0d", r));
         for (int c = 0; c < CH; c++)
            chk_rng($sformatf("row%0d_density_ch%0d", r, c), ones[c],
                    int'(rows[r].lo[c]), int'(rows[r].hi[c]));
         chk($sformatf("row%0d_no_overflow", r), {28'd0, ovf_a}, 32'd0);
      end

      // Mode switches mid-stream
      order_2nd = 4'b1111;
      cur_x[0] = 1500000; cur_x[1] = -2500000; cur_x[2] = 0; cur_x[3] = 3000000;
      do_clear();
      for (int p = 0; p < 6; p++) do_period((p == 0) ? 4 : DIV, "mode_a");
      order_2nd = 4'b0101;
      for (int p = 0; p < 6; p++) do_period(DIV, "mode_b");
      order_2nd = 4'b1010;
      for (int p = 0; p < 6; p++) do_period(DIV, "mode_c");

      // Freeze at cnt=2 for 7 cycles
      enable = 1'b0;
      order_2nd = 4'b1010;
      cur_x[0] = 100000; cur_x[1] = -200000; cur_x[2] = 300000; cur_x[3] = 0;
      drive();
      do_clear();
      push_expect();
      enable = 1'b1;
      repeat (2) @(negedge clock);
      enable = 1'b0;
      cur_x[0] = -5000000;
      drive();
      for (int k = 0; k < 7; k++) begin
         @(negedge clock);
         chk($sformatf("freeze_no_valid_%0d", k), {31'd0, bv_a}, 32'd0);
      end
      enable = 1'b1;
      @(negedge clock);
      chk("freeze_resume_ch2", {31'd0, bv_a}, 32'd0);
      wait_pop(1, "freeze_resume_ch3");

      // Overflow with ACC_GUARD=0: full-scale positive input on channel 0
      enable = 1'b0;
      order_2nd = 4'b1111;
      cur_x[0] = int'(FULL_POS); cur_x[1] = 0; cur_x[2] = 0; cur_x[3] = 0;
      drive();
      do_clear();
      push_expect();
      enable = 1'b1;
      @(negedge clock);
      chk("ovf_first_update", {31'd0, ovf_b[0]}, 32'd1);
      chk("ovf_none_guard4", {28'd0, ovf_a}, 32'd0);
      wait_pop(3, "ovf_p0");
      for (int p = 0; p < 50; p++) begin
         do_period(DIV, "ovf_hold");
         chk("ovf_sticky", {31'd0, ovf_b[0]}, 32'd1);
      end

      // Clear mid-period, after channels 0 and 1 have updated
      repeat (8) @(negedge clock);
      do_clear();
      chk("clear_bits", {28'd0, out_a}, 32'd0);
      chk("clear_bits_g0", {28'd0, out_b}, 32'd0);
      chk("clear_valid", {31'd0, bv_a}, 32'd0);
      chk("clear_keeps_ovf", {31'd0, ovf_b[0]}, 32'd1);
      do_period(4, "after_clear");

      // overflow_clear on an idle slot: nothing clamps on that edge
      overflow_clear = 1'b1;
      @(negedge clock);
      overflow_clear = 1'b0;
      chk("ovf_clear", {28'd0, ovf_b}, 32'd0);

      // overflow_clear on the edge where channel 0 clamps: set wins
      do_clear();
      drive();
      push_expect();
      overflow_clear = 1'b1;
      @(negedge clock);
      overflow_clear = 1'b0;
      chk("ovf_set_wins", {28'd0, ovf_b}, 32'h1);
      wait_pop(3, "ovf_coincident");

      // Asynchronous reset between clock edges
      @(posedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_reset_bits", {28'd0, out_a}, 32'd0);
      chk("async_reset_bits_g0", {28'd0, out_b}, 32'd0);
      chk("async_reset_valid", {31'd0, bv_a}, 32'd0);
      chk("async_reset_ovf_g0", {28'd0, ovf_b}, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      model_clear();
      do_period(4, "after_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
